// File: rtl/icmp_pkg.sv
// Shared ICMP definitions: type codes, header size and checker state encoding.
package icmp_pkg;

    localparam logic [7:0] ECHO_REPLY    = 8'd0;
    localparam logic [7:0] DEST_UNREACH  = 8'd3;
    localparam logic [7:0] ECHO_REQUEST  = 8'd8;
    localparam logic [7:0] TIME_EXCEEDED = 8'd11;

    localparam int unsigned ICMP_HDR_WORDS = 2;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        FOLD1,
        FOLD2,
        DONE
    } chk_state_e;

endpackage

// File: rtl/icmp_ones_fold.sv
// Combinational end-around-carry fold: low 16 bits plus everything above bit 15.
module icmp_ones_fold #(
    parameter int unsigned ACC_W = 22
) (
    input  logic [ACC_W-1:0] din,
    output logic [ACC_W-1:0] sum_c
);

    // Add the carry-out bits back into the low half.
    always_comb begin
        sum_c = ACC_W'(din[15:0]) + ACC_W'(din[ACC_W-1:16]);
    end

endmodule

// File: rtl/icmp_checksum_checker.sv
// Receive-side ICMP checksum checker: sums a message of 32-bit words in
// ones'-complement, folds the accumulator twice and reports the verdict.
module icmp_checksum_checker
    import icmp_pkg::*;
#(
    parameter int unsigned MIN_WORDS = ICMP_HDR_WORDS,
    parameter int unsigned MAX_WORDS = 16
) (
    input  logic        clock,
    input  logic        hardreset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_ok,
    output logic [15:0] res_sum,
    output logic [7:0]  res_type,
    output logic [7:0]  res_code,
    output logic        res_len_err
);

    localparam int unsigned ACC_W = 16 + $clog2(2 * MAX_WORDS) + 1;
    // Count saturates at MAX_WORDS+1 so an overlong message stays flagged.
    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 2);

    chk_state_e       state;
    chk_state_e       state_nxt;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [ACC_W-1:0] word_sum;
    logic [ACC_W-1:0] fold_sum;
    logic [7:0]       hdr_type;
    logic [7:0]       hdr_code;
    logic             xfer;
    logic             len_err;

    icmp_ones_fold #(
        .ACC_W (ACC_W)
    ) u_fold (
        .din   (acc),
        .sum_c (fold_sum)
    );

    // Word handshake and per-word contribution of both 16-bit fields.
    always_comb begin
        xfer     = in_valid & in_ready;
        word_sum = ACC_W'(in_data[31:16]) + ACC_W'(in_data[15:0]);
        len_err  = (cnt < CNT_W'(MIN_WORDS)) | (cnt > CNT_W'(MAX_WORDS));
    end

    // State register.
    always_ff @(posedge clock or posedge hardreset) begin
        if (hardreset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, accumulator and word-count logic.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (xfer) begin
                    acc_nxt   = word_sum;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = in_last ? FOLD1 : ACC;
                end
            end
            ACC: begin
                if (xfer) begin
                    if (cnt < CNT_W'(MAX_WORDS)) begin
                        acc_nxt = acc + word_sum;
                    end
                    if (cnt <= CNT_W'(MAX_WORDS)) begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                    if (in_last) begin
                        state_nxt = FOLD1;
                    end
                end
            end
            FOLD1: begin
                acc_nxt   = fold_sum;
                state_nxt = FOLD2;
            end
            FOLD2: begin
                acc_nxt   = fold_sum;
                state_nxt = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: accumulator, count and captured header fields.
    always_ff @(posedge clock or posedge hardreset) begin
        if (hardreset) begin
            acc      <= '0;
            cnt      <= '0;
            hdr_type <= '0;
            hdr_code <= '0;
        end else begin
            acc <= acc_nxt;
            cnt <= cnt_nxt;
            if (state == IDLE && xfer) begin
                hdr_type <= in_data[31:24];
                hdr_code <= in_data[23:16];
            end
        end
    end

    // Registered outputs; result fields are captured once, on the last fold.
    always_ff @(posedge clock or posedge hardreset) begin
        if (hardreset) begin
            in_ready    <= 1'b1;
            res_valid   <= 1'b0;
            res_ok      <= 1'b0;
            res_sum     <= '0;
            res_type    <= '0;
            res_code    <= '0;
            res_len_err <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE) || (state_nxt == ACC);
            res_valid <= (state_nxt == DONE);
            if (state == FOLD2) begin
                res_sum     <= ~fold_sum[15:0];
                res_len_err <= len_err;
                res_ok      <= (fold_sum[15:0] == 16'hFFFF) & ~len_err;
                res_type    <= hdr_type;
                res_code    <= hdr_code;
            end
        end
    end

endmodule

// File: tb/tb_icmp_checksum_checker.sv
// Bench for icmp_checksum_checker: vector table through a scoreboard, plus
// backpressure and mid-message reset sequences.
module tb_icmp_checksum_checker;
    import icmp_pkg::*;

    logic        clock = 1'b0;
    logic        hardreset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        res_valid;
    logic        res_ready;
    logic        res_ok;
    logic [15:0] res_sum;
    logic [7:0]  res_type;
    logic [7:0]  res_code;
    logic        res_len_err;

    icmp_checksum_checker dut (
        .clock       (clock),
        .hardreset   (hardreset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_ok      (res_ok),
        .res_sum     (res_sum),
        .res_type    (res_type),
        .res_code    (res_code),
        .res_len_err (res_len_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        ok;
        logic [15:0] sum;
        logic [7:0]  typ;
        logic [7:0]  code;
        logic        len_err;
    } exp_t;

    typedef struct packed {
        logic [16:0][31:0] words;
        logic [4:0]        n;
        exp_t              exp;
    } vec_t;

    localparam int NVEC = 8;

    vec_t vecs [NVEC];
    exp_t sb [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Drive a message word by word; returns the number of cycles stalled.
    task automatic send_msg(input vec_t v, output int stalls);
        logic acc;
        stalls = 0;
        for (int j = 0; j < int'(v.n); j++) begin
            in_valid = 1'b1;
            in_data  = v.words[j];
            in_last  = (j == int'(v.n) - 1);
            acc      = 1'b0;
            for (int t = 0; t < 50 && !acc; t++) begin
                @(negedge clock);
                acc = in_ready;
                if (!acc) stalls++;
                @(posedge clock);
                #1;
            end
            if (!acc) begin
                check("accept_timeout", 32'(acc), 32'd1);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait for a result, pop the scoreboard and compare every field.
    task automatic wait_result(input string name, input bit chk_lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!res_valid && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        if (chk_lat) check({name, "_latency"}, 32'(cyc), 32'd2);
        if (!res_valid) begin
            check({name, "_res_valid_timeout"}, 32'(res_valid), 32'd1);
            return;
        end
        if (sb.size() == 0) begin
            check({name, "_scoreboard_empty"}, 32'(sb.size()), 32'd1);
            return;
        end
        e = sb.pop_front();
        check({name, "_ok"},      32'(res_ok),      32'(e.ok));
        check({name, "_sum"},     32'(res_sum),     32'(e.sum));
        check({name, "_type"},    32'(res_type),    32'(e.typ));
        check({name, "_code"},    32'(res_code),    32'(e.code));
        check({name, "_len_err"}, 32'(res_len_err), 32'(e.len_err));
    endtask

    // Accept the pending result and confirm the checker is free again.
    task automatic accept_result(input string name);
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(res_valid), 32'd0);
        check({name, "_ready_back"}, 32'(in_ready),  32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int stalls;
        sb.push_back(v.exp);
        send_msg(v, stalls);
        check({name, "_stalls"}, 32'(stalls), 32'd0);
        wait_result(name, 1'b1);
        accept_result(name);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_in_ready"},    32'(in_ready),    32'd1);
        check({name, "_res_valid"},   32'(res_valid),   32'd0);
        check({name, "_res_ok"},      32'(res_ok),      32'd0);
        check({name, "_res_sum"},     32'(res_sum),     32'd0);
        check({name, "_res_type"},    32'(res_type),    32'd0);
        check({name, "_res_code"},    32'(res_code),    32'd0);
        check({name, "_res_len_err"}, 32'(res_len_err), 32'd0);
    endtask

    initial begin
        int stalls;

        // Vector table: message words and expected verdict.
        for (int i = 0; i < NVEC; i++) vecs[i] = '0;
        // good echo request
        vecs[0].words[0] = 32'h0800F7FD; vecs[0].words[1] = 32'h00010001; vecs[0].n = 5'd2;
        vecs[0].exp = '{ok: 1'b1, sum: 16'h0000, typ: ECHO_REQUEST, code: 8'd0, len_err: 1'b0};
        // corrupted checksum
        vecs[1].words[0] = 32'h0800F7FC; vecs[1].words[1] = 32'h00010001; vecs[1].n = 5'd2;
        vecs[1].exp = '{ok: 1'b0, sum: 16'h0001, typ: ECHO_REQUEST, code: 8'd0, len_err: 1'b0};
        // raw sum 0x2FFFD needs carry folding
        vecs[2].words[0] = 32'hFFFFFFFF; vecs[2].words[1] = 32'hFFFF0000; vecs[2].n = 5'd2;
        vecs[2].exp = '{ok: 1'b1, sum: 16'h0000, typ: 8'hFF, code: 8'hFF, len_err: 1'b0};
        // single word: too short even though the sum folds to 0xFFFF
        vecs[3].words[0] = 32'h0800F7FF; vecs[3].n = 5'd1;
        vecs[3].exp = '{ok: 1'b0, sum: 16'h0000, typ: ECHO_REQUEST, code: 8'd0, len_err: 1'b1};
        // all-zero message: positive zero fails
        vecs[4].n = 5'd2;
        vecs[4].exp = '{ok: 1'b0, sum: 16'hFFFF, typ: ECHO_REPLY, code: 8'd0, len_err: 1'b0};
        // 17 words: last word not summed, length error
        vecs[5].words[0] = 32'h0B000000;
        for (int j = 1; j < 16; j++) vecs[5].words[j] = 32'h00010001;
        vecs[5].words[16] = 32'hFFFFFFFF; vecs[5].n = 5'd17;
        vecs[5].exp = '{ok: 1'b0, sum: 16'hF4E1, typ: TIME_EXCEEDED, code: 8'd0, len_err: 1'b1};
        // exactly 16 words, good
        vecs[6].words[0] = 32'h0300FCE1;
        for (int j = 1; j < 16; j++) vecs[6].words[j] = 32'h00010001;
        vecs[6].n = 5'd16;
        vecs[6].exp = '{ok: 1'b1, sum: 16'h0000, typ: DEST_UNREACH, code: 8'd0, len_err: 1'b0};
        // non-zero code byte, bad checksum
        vecs[7].words[0] = 32'h00010000; vecs[7].n = 5'd2;
        vecs[7].exp = '{ok: 1'b0, sum: 16'hFFFE, typ: ECHO_REPLY, code: 8'd1, len_err: 1'b0};

        hardreset = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        #2;
        check_reset_outputs("por");
        #10;
        hardreset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held while the next message waits at the input.
        sb.push_back(vecs[0].exp);
        send_msg(vecs[0], stalls);
        wait_result("bp", 1'b1);
        in_valid = 1'b1;
        in_data  = vecs[0].words[0];
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            check($sformatf("bp_hold%0d_in_ready", c),  32'(in_ready),  32'd0);
            check($sformatf("bp_hold%0d_res_valid", c), 32'(res_valid), 32'd1);
            check($sformatf("bp_hold%0d_res_sum", c),   32'(res_sum),   32'h0000);
            check($sformatf("bp_hold%0d_res_ok", c),    32'(res_ok),    32'd1);
            @(posedge clock);
            #1;
        end
        accept_result("bp");
        run_vec(vecs[0], "bp_next");

        // Reset after word 1 of 2: partial message and old result are lost.
        in_valid = 1'b1;
        in_data  = 32'h0800F7FD;
        in_last  = 1'b0;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        #2;
        hardreset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        #2;
        hardreset = 1'b0;
        @(posedge clock);
        #1;
        run_vec(vecs[0], "after_rst");

        if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/icmp_checksum_checker.md
Name: icmp_checksum_checker

Overview:
Receive-side counterpart of the ICMP checksum generator. Accepts an incoming ICMP message as a stream of 32-bit words and accumulates the 16-bit ones'-complement sum over the whole message, including the embedded checksum field. It reports pass/fail, the computed residual checksum, the message type/code and a length error. Sits between the receive word buffer and the ICMP reply/dispatch logic.

Parameters:
MIN_WORDS, 2, minimum legal message length in 32-bit words (8-byte ICMP header)
MAX_WORDS, 16, maximum words summed; additional words are consumed and discarded
ACC_W, 16+$clog2(2*MAX_WORDS)+1, accumulator width; derived, do not override

Ports:
clock  in  1  system clock, all logic on rising edge
hardreset  in  1  asynchronous, active-high reset
in_data  in  32  message word; [31:16] is the first 16-bit field, [15:0] the second
in_valid  in  1  in_data/in_last valid
in_last  in  1  final word of the message
in_ready  out  1  checker can accept a word
res_valid  out  1  result available, held until accepted
res_ready  in  1  downstream accepts the result
res_ok  out  1  checksum correct and length legal
res_sum  out  16  ~(folded sum); 16'h0000 on a good message
res_type  out  8  in_data[31:24] of the first word
res_code  out  8  in_data[23:16] of the first word
res_len_err  out  1  word count < MIN_WORDS or > MAX_WORDS

Behaviour:
- Reset (async, any time, including mid-message or while a result is pending): state=IDLE, acc=0, word count=0. Outputs: in_ready=1, res_valid=0, res_ok=0, res_sum=0, res_type=0, res_code=0, res_len_err=0. Any partial message is lost.
- Word transfer occurs on a rising edge with in_valid&in_ready. in_ready=1 only in IDLE and ACC.
- IDLE: on transfer, acc<=in_data[31:16]+in_data[15:0] (zero-extended), latch type/code, count<=1. Go to ACC; if in_last, go to FOLD1 instead.
- ACC: on transfer with count<MAX_WORDS, acc<=acc+hi+lo. At count>=MAX_WORDS the word is not summed. In both cases the count increments, saturating at MAX_WORDS+1. If in_last, go to FOLD1.
- FOLD1/FOLD2: each state does acc<=acc[15:0]+acc[ACC_W-1:16], one cycle each. Two folds always suffice at the default ACC_W. Then go to DONE.
- DONE: res_valid=1. Outputs are registered and stable while res_valid=1:
  - res_sum=~acc[15:0]
  - res_len_err=(count<MIN_WORDS)|(count>MAX_WORDS)
  - res_ok=(acc[15:0]==16'hFFFF)&~res_len_err
  - On res_ready=1, go to IDLE; res_valid drops on that edge.
- Latency: last word accepted at edge N gives res_valid=1 after edge N+2. While a result is pending, in_ready=0 (backpressure); no result is ever overwritten.
- A 16'h0000 folded sum (all-zero message) fails. The negative-zero convention applies, matching the generator.
- in_valid while in_ready=0: the word is held by the source, not dropped.
- Throughput: one word per cycle, plus 3 cycles per message (2 fold cycles + 1 handshake minimum).

Decomposition:
- Shared package icmp_pkg:
  - ICMP type constants: ECHO_REPLY=0, DEST_UNREACH=3, ECHO_REQUEST=8, TIME_EXCEEDED=11.
  - Checker state enum IDLE/ACC/FOLD1/FOLD2/DONE.
  - ICMP_HDR_WORDS=2.
- One natural sub-module: icmp_ones_fold. This is a combinational end-around-carry fold of an ACC_W vector to ACC_W, reusable by the generator.

Test Plan:
- Good echo request: words 32'h0800F7FD, 32'h00010001 (last) -> 2 edges after the last accept, res_valid=1, res_ok=1, res_sum=16'h0000, res_type=8, res_code=0, res_len_err=0.
- Corrupted checksum: words 32'h0800F7FC, 32'h00010001 (last) -> res_ok=0, res_sum=16'h0001.
- Carry folding: words 32'hFFFFFFFF, 32'hFFFF0000 (last) -> raw sum 0x2FFFD folds to 0xFFFF, so res_ok=1, res_sum=0.
- Length violations:
  - Single word 32'h0800F7FF with in_last -> res_len_err=1, res_ok=0.
  - MAX_WORDS+1 words ending in last -> res_len_err=1, res_ok=0, in_ready stays 1 throughout.
- Backpressure: hold res_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, results stable, no word consumed. Assert res_ready -> the next message is accepted starting on the following edge.
- Reset mid-message: assert hardreset after word 1 of 2 -> all outputs return to reset values immediately. A new good message afterwards yields res_ok=1.
